// File: rtl/imem_loader.sv
// Boot loader: assembles a host byte stream into 32-bit words, writes them to instruction memory, then hands the port to the CPU.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte checked before RUN.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256,
  parameter int LEN_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [31:0]       cpu_instr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_WE,
  output logic [31:0]       mem_WD,
  input  logic [31:0]       mem_RD,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, RUN, CHECK} state_t;
  localparam state_t LOADED = CHECK;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;
  localparam state_t LOADED = RUN;
`endif

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] word_next;
  logic [1:0]       byte_idx;
  logic [31:0]      asm_word;
  logic             err_q;
  logic             accept;
  logic             can_start;
  logic             start_ok;
  logic             start_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // A new load may only begin while the port is idle or owned by the CPU.
  assign can_start = (state_q == IDLE) || (state_q == RUN);
  assign start_bad = can_start && start && (len_words > MAX_LEN);
  assign start_ok  = can_start && start && !(len_words > MAX_LEN);
  assign accept    = byte_valid && byte_ready;
  assign word_next = word_idx + LEN_W'(1);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (start_ok) begin
          state_d = (len_words == '0) ? LOADED : RECV;
        end
      end
      RECV: begin
        if (accept && (byte_idx == 2'd3)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = (word_next == len_q) ? LOADED : RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_d = (byte_data == csum) ? RUN : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The memory port is shared: the loader drives it in WRITE, the CPU fetch path owns it in RUN.
  always_comb begin
    byte_ready = 1'b0;
    mem_WE     = 1'b0;
    mem_A      = '0;
    mem_WD     = '0;
    cpu_instr  = '0;
    cpu_stall  = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        mem_WE = 1'b1;
        mem_A  = {word_idx[ADDR_W-3:0], 2'b00};
        mem_WD = asm_word;
        busy   = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      RUN: begin
        mem_A     = cpu_pc;
        cpu_instr = mem_RD;
        cpu_stall = 1'b0;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (start_bad) begin
        err_q <= 1'b1;
      end
      if (start_ok) begin
        err_q    <= 1'b0;
        len_q    <= len_words;
        word_idx <= '0;
        byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      // Little-endian assembly: the k-th byte of a word lands in bits [8k+7:8k].
      if ((state_q == RECV) && accept) begin
        asm_word[{byte_idx, 3'b000} +: 8] <= byte_data;
        byte_idx                          <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum                              <= csum + byte_data;
`endif
      end
      if (state_q == WRITE) begin
        word_idx <= word_next;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((state_q == CHECK) && accept && (byte_data != csum)) begin
        err_q <= 1'b1;
      end
`endif
    end
  end

endmodule
